// File: rtl/rob_ss_if.sv
// Bundle of dispatch, completion, query, retire and squash signals between the
// reorder buffer and the rest of the core.
interface rob_ss_if #(
    parameter int XLEN     = 32,
    parameter int ROB_SIZE = 32,
    parameter int DISP_W   = 2,
    parameter int CMPL_W   = 2,
    parameter int RET_W    = 2,
    parameter int QRY_W    = 4,
    parameter int IDX_W    = $clog2(ROB_SIZE)
);
    // Dispatch slot k is taken on a rising edge only when dispatch_valid[k] and
    // dispatch_ready are both high; completion, retire and squash are
    // single-cycle strobes with no back-pressure.
    logic [DISP_W-1:0]        dispatch_valid;
    logic [DISP_W*XLEN-1:0]   dispatch_pc;
    logic [DISP_W*5-1:0]      dispatch_dest_reg;
    logic                     dispatch_ready;
    logic [DISP_W*IDX_W-1:0]  dispatch_idx;
    logic [CMPL_W-1:0]        complete_valid;
    logic [CMPL_W*IDX_W-1:0]  complete_idx;
    logic [CMPL_W*XLEN-1:0]   complete_value;
    logic [CMPL_W-1:0]        complete_mispred;
    logic [CMPL_W*XLEN-1:0]   complete_target;
    logic [QRY_W*IDX_W-1:0]   query_idx;
    logic [QRY_W-1:0]         query_ready;
    logic [QRY_W*XLEN-1:0]    query_value;
    logic [RET_W-1:0]         retire_valid;
    logic [RET_W*5-1:0]       retire_dest_reg;
    logic [RET_W*XLEN-1:0]    retire_value;
    logic                     squash;
    logic [XLEN-1:0]          squash_target;
    logic [IDX_W:0]           rob_count;
    logic                     rob_empty;

    modport master (
        output dispatch_valid, dispatch_pc, dispatch_dest_reg,
        output complete_valid, complete_idx, complete_value, complete_mispred, complete_target,
        output query_idx,
        input  dispatch_ready, dispatch_idx, query_ready, query_value,
        input  retire_valid, retire_dest_reg, retire_value,
        input  squash, squash_target, rob_count, rob_empty
    );

    modport slave (
        input  dispatch_valid, dispatch_pc, dispatch_dest_reg,
        input  complete_valid, complete_idx, complete_value, complete_mispred, complete_target,
        input  query_idx,
        output dispatch_ready, dispatch_idx, query_ready, query_value,
        output retire_valid, retire_dest_reg, retire_value,
        output squash, squash_target, rob_count, rob_empty
    );
endinterface

// File: rtl/rob_ss.sv
// Multi-way reorder buffer: in-order dispatch and retire, out-of-order CDB
// completion, operand queries with CDB bypass, full flush on a retiring mispredict.
module rob_ss #(
    parameter int XLEN     = 32,
    parameter int ROB_SIZE = 32,
    parameter int DISP_W   = 2,
    parameter int CMPL_W   = 2,
    parameter int RET_W    = 2,
    parameter int QRY_W    = 4,
    parameter int IDX_W    = $clog2(ROB_SIZE)
) (
    input  logic     clock,
    input  logic     reset,
    rob_ss_if.slave  bus
);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      dest;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] target;
        logic            mispred;
    } ent_t;

    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_cmpl;
    ent_t                r_ent [ROB_SIZE];
    logic [IDX_W-1:0]    r_head;
    logic [IDX_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic [IDX_W-1:0]    w_didx [DISP_W];
    logic [IDX_W-1:0]    w_ridx [RET_W];
    logic [IDX_W-1:0]    w_cidx [CMPL_W];
    logic                w_ready;
    logic                w_chain;
    logic [DISP_W-1:0]   w_acc;
    logic [CNT_W-1:0]    w_n_acc;
    logic                w_run;
    logic [RET_W-1:0]    w_ret;
    logic [CNT_W-1:0]    w_n_ret;
    logic                w_squash;
    logic [XLEN-1:0]     w_sq_target;
    logic [IDX_W-1:0]    w_qidx;
    logic                w_qrdy;
    logic [XLEN-1:0]     w_qval;

    always_comb begin
        for (int k = 0; k < DISP_W; k++) w_didx[k] = r_tail + IDX_W'(k);
        for (int j = 0; j < RET_W; j++)  w_ridx[j] = r_head + IDX_W'(j);
        for (int p = 0; p < CMPL_W; p++) w_cidx[p] = bus.complete_idx[p*IDX_W +: IDX_W];
    end

    // Readiness looks only at the registered count, so slots freed by this
    // cycle's retirements are offered from the next cycle on.
    always_comb begin
        w_ready = (r_count <= CNT_W'(ROB_SIZE - DISP_W));
        w_acc   = '0;
        w_n_acc = '0;
        w_chain = 1'b1;
        bus.dispatch_idx = '0;
        for (int k = 0; k < DISP_W; k++) begin
            w_chain  = w_chain & bus.dispatch_valid[k];
            w_acc[k] = w_chain & w_ready;
            w_n_acc  = w_n_acc + CNT_W'(w_acc[k]);
            bus.dispatch_idx[k*IDX_W +: IDX_W] = w_didx[k];
        end
    end

    always_comb begin
        w_ret       = '0;
        w_n_ret     = '0;
        w_squash    = 1'b0;
        w_sq_target = '0;
        w_run       = 1'b1;
        bus.retire_dest_reg = '0;
        bus.retire_value    = '0;
        for (int j = 0; j < RET_W; j++) begin
            if (w_run && r_valid[w_ridx[j]] && r_cmpl[w_ridx[j]]) begin
                w_ret[j] = 1'b1;
                w_n_ret  = w_n_ret + CNT_W'(1);
                bus.retire_dest_reg[j*5 +: 5]  = r_ent[w_ridx[j]].dest;
                bus.retire_value[j*XLEN +: XLEN] = r_ent[w_ridx[j]].value;
                if (r_ent[w_ridx[j]].mispred) begin
                    w_squash    = 1'b1;
                    w_sq_target = r_ent[w_ridx[j]].target;
                    w_run       = 1'b0;
                end
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // CDB bypass beats stored state; scanning ports downward lets port 0 win.
    always_comb begin
        w_qidx = '0;
        w_qrdy = 1'b0;
        w_qval = '0;
        bus.query_ready = '0;
        bus.query_value = '0;
        for (int q = 0; q < QRY_W; q++) begin
            w_qidx = bus.query_idx[q*IDX_W +: IDX_W];
            w_qrdy = r_valid[w_qidx] & r_cmpl[w_qidx];
            w_qval = w_qrdy ? r_ent[w_qidx].value : '0;
            for (int p = CMPL_W - 1; p >= 0; p--) begin
                if (bus.complete_valid[p] && (w_cidx[p] == w_qidx)) begin
                    w_qrdy = 1'b1;
                    w_qval = bus.complete_value[p*XLEN +: XLEN];
                end
            end
            bus.query_ready[q] = w_qrdy;
            bus.query_value[q*XLEN +: XLEN] = w_qval;
        end
    end

    assign bus.dispatch_ready = w_ready;
    assign bus.retire_valid   = w_ret;
    assign bus.squash         = w_squash;
    assign bus.squash_target  = w_sq_target;
    assign bus.rob_count      = r_count;
    assign bus.rob_empty      = (r_count == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_cmpl  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < ROB_SIZE; i++) r_ent[i] <= '0;
        end else if (w_squash) begin
            r_valid <= '0;
            r_cmpl  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int p = CMPL_W - 1; p >= 0; p--) begin
                if (bus.complete_valid[p] && r_valid[w_cidx[p]]) begin
                    r_cmpl[w_cidx[p]]          <= 1'b1;
                    r_ent[w_cidx[p]].value   <= bus.complete_value[p*XLEN +: XLEN];
                    r_ent[w_cidx[p]].mispred <= bus.complete_mispred[p];
                    r_ent[w_cidx[p]].target  <= bus.complete_target[p*XLEN +: XLEN];
                end
            end
            for (int j = 0; j < RET_W; j++) begin
                if (w_ret[j]) begin
                    r_valid[w_ridx[j]] <= 1'b0;
                    r_cmpl[w_ridx[j]]  <= 1'b0;
                end
            end
            // Dispatch targets free entries only, so it never collides with
            // a completion or retirement of the same entry.
            for (int k = 0; k < DISP_W; k++) begin
                if (w_acc[k]) begin
                    r_valid[w_didx[k]] <= 1'b1;
                    r_cmpl[w_didx[k]]  <= 1'b0;
                    r_ent[w_didx[k]]   <= '{pc:      bus.dispatch_pc[k*XLEN +: XLEN],
                                             dest:    bus.dispatch_dest_reg[k*5 +: 5],
                                             value:   '0,
                                             target:  '0,
                                             mispred: 1'b0};
                end
            end
            r_head  <= r_head + w_n_ret[IDX_W-1:0];
            r_tail  <= r_tail + w_n_acc[IDX_W-1:0];
            r_count <= r_count + w_n_acc - w_n_ret;
        end
    end
endmodule

// File: tb/tb_rob_ss.sv
// Bench for rob_ss: directed scenarios plus random traffic, all outputs checked
// every cycle against a queue-of-entries model of the reorder buffer.
module tb_rob_ss;
    localparam int XLEN     = 32;
    localparam int ROB_SIZE = 32;
    localparam int DISP_W   = 2;
    localparam int CMPL_W   = 2;
    localparam int RET_W    = 2;
    localparam int QRY_W    = 4;
    localparam int IDX_W    = 5;

    logic clock;
    logic reset;

    rob_ss_if #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .DISP_W(DISP_W), .CMPL_W(CMPL_W),
                .RET_W(RET_W), .QRY_W(QRY_W), .IDX_W(IDX_W)) bus ();

    rob_ss #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .DISP_W(DISP_W), .CMPL_W(CMPL_W),
             .RET_W(RET_W), .QRY_W(QRY_W), .IDX_W(IDX_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: occupied entries oldest first, plus the next allocation index.
    typedef struct packed {
        logic [4:0]  idx;
        logic [4:0]  dest;
        logic [31:0] value;
        logic [31:0] target;
        logic        done;
        logic        mispred;
    } m_ent_t;

    m_ent_t exp_q[$];
    int     m_tail;
    int     m_nret;
    bit     m_squash;
    bit     m_ready;
    int     total;
    int     bad;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.dispatch_valid    = '0;
        bus.dispatch_pc       = '0;
        bus.dispatch_dest_reg = '0;
        bus.complete_valid    = '0;
        bus.complete_idx      = '0;
        bus.complete_value    = '0;
        bus.complete_mispred  = '0;
        bus.complete_target   = '0;
        bus.query_idx         = '0;
    endtask

    task automatic disp(input logic [1:0] dv, input logic [31:0] pc0, input logic [4:0] d0,
                        input logic [31:0] pc1, input logic [4:0] d1);
        bus.dispatch_valid    = dv;
        bus.dispatch_pc       = {pc1, pc0};
        bus.dispatch_dest_reg = {d1, d0};
    endtask

    task automatic cmpl(input int p, input logic [4:0] idx, input logic [31:0] val,
                        input logic mis, input logic [31:0] tgt);
        bus.complete_valid[p]                = 1'b1;
        bus.complete_idx[p*IDX_W +: IDX_W]   = idx;
        bus.complete_value[p*XLEN +: XLEN]   = val;
        bus.complete_mispred[p]              = mis;
        bus.complete_target[p*XLEN +: XLEN]  = tgt;
    endtask

    // Compare every output against the model for the inputs now applied.
    task automatic check_outputs();
        int          stop;
        int          found;
        logic [4:0]  qi;
        logic        e_qr;
        logic [31:0] e_qv;
        logic [31:0] e_tgt;
        m_ready = (exp_q.size() <= ROB_SIZE - DISP_W);
        chk("dispatch_ready", bus.dispatch_ready, m_ready);
        for (int k = 0; k < DISP_W; k++)
            chk("dispatch_idx", bus.dispatch_idx[k*IDX_W +: IDX_W], (m_tail + k) % ROB_SIZE);
        chk("rob_count", bus.rob_count, exp_q.size());
        chk("rob_empty", bus.rob_empty, exp_q.size() == 0);
        m_nret   = 0;
        m_squash = 0;
        stop     = 0;
        e_tgt    = '0;
        for (int j = 0; j < RET_W; j++) begin
            if (stop == 0 && j < exp_q.size() && exp_q[j].done) begin
                m_nret++;
                chk("retire_dest", bus.retire_dest_reg[j*5 +: 5], exp_q[j].dest);
                chk("retire_value", bus.retire_value[j*XLEN +: XLEN], exp_q[j].value);
                if (exp_q[j].mispred) begin
                    m_squash = 1;
                    e_tgt    = exp_q[j].target;
                    stop     = 1;
                end
            end else begin
                stop = 1;
            end
        end
        chk("retire_valid", bus.retire_valid, (1 << m_nret) - 1);
        chk("squash", bus.squash, m_squash);
        if (m_squash) chk("squash_target", bus.squash_target, e_tgt);
        for (int q = 0; q < QRY_W; q++) begin
            qi    = bus.query_idx[q*IDX_W +: IDX_W];
            e_qr  = 1'b0;
            e_qv  = '0;
            found = 0;
            for (int p = 0; p < CMPL_W; p++) begin
                if (found == 0 && bus.complete_valid[p] && bus.complete_idx[p*IDX_W +: IDX_W] == qi) begin
                    e_qr  = 1'b1;
                    e_qv  = bus.complete_value[p*XLEN +: XLEN];
                    found = 1;
                end
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                if (found == 0 && exp_q[i].idx == qi && exp_q[i].done) begin
                    e_qr  = 1'b1;
                    e_qv  = exp_q[i].value;
                    found = 1;
                end
            end
            chk("query_ready", bus.query_ready[q], e_qr);
            chk("query_value", bus.query_value[q*XLEN +: XLEN], e_qv);
        end
    endtask

    task automatic model_step();
        m_ent_t e;
        if (m_squash) begin
            exp_q.delete();
            m_tail = 0;
            return;
        end
        for (int p = CMPL_W - 1; p >= 0; p--) begin
            if (bus.complete_valid[p]) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (exp_q[i].idx == bus.complete_idx[p*IDX_W +: IDX_W]) begin
                        e         = exp_q[i];
                        e.done    = 1'b1;
                        e.value   = bus.complete_value[p*XLEN +: XLEN];
                        e.mispred = bus.complete_mispred[p];
                        e.target  = bus.complete_target[p*XLEN +: XLEN];
                        exp_q[i]  = e;
                    end
                end
            end
        end
        repeat (m_nret) void'(exp_q.pop_front());
        if (m_ready) begin
            for (int k = 0; k < DISP_W; k++) begin
                if (!bus.dispatch_valid[k]) break;
                e = '0;
                e.idx  = 5'(m_tail);
                e.dest = bus.dispatch_dest_reg[k*5 +: 5];
                exp_q.push_back(e);
                m_tail = (m_tail + 1) % ROB_SIZE;
            end
        end
    endtask

    task automatic settle();
        #3;
        check_outputs();
    endtask

    task automatic advance();
        model_step();
        @(posedge clock);
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_count", bus.rob_count, 0);
        chk("rst_empty", bus.rob_empty, 1);
        chk("rst_retire_valid", bus.retire_valid, 0);
        chk("rst_squash", bus.squash, 0);
        chk("rst_dispatch_ready", bus.dispatch_ready, 1);
        exp_q.delete();
        m_tail = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic drain();
        int guard;
        int n;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            n = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (!exp_q[i].done && n < CMPL_W) begin
                    cmpl(n, exp_q[i].idx, $urandom, 1'b0, '0);
                    n++;
                end
            end
            step();
            guard++;
        end
        if (exp_q.size() > 0) chk("drain_bound", exp_q.size(), 0);
    endtask

    task automatic rand_inputs();
        int r;
        r = $urandom_range(0, 9);
        disp((r < 3) ? 2'b00 : (r == 3) ? 2'b10 : (r < 7) ? 2'b01 : 2'b11,
             $urandom, 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)));
        for (int p = 0; p < CMPL_W; p++) begin
            if ($urandom_range(0, 2) != 0) begin
                if (exp_q.size() > 0 && $urandom_range(0, 3) != 0)
                    cmpl(p, exp_q[$urandom_range(0, exp_q.size() - 1)].idx, $urandom,
                         $urandom_range(0, 19) == 0, $urandom);
                else
                    cmpl(p, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 19) == 0, $urandom);
            end
        end
        for (int q = 0; q < QRY_W; q++) begin
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 0)
                bus.query_idx[q*IDX_W +: IDX_W] = exp_q[$urandom_range(0, exp_q.size() - 1)].idx;
            else
                bus.query_idx[q*IDX_W +: IDX_W] = 5'($urandom_range(0, 31));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        m_tail = 0;
        idle_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clock);
        #1;
        chk("init_count", bus.rob_count, 0);
        chk("init_empty", bus.rob_empty, 1);
        chk("init_retire_valid", bus.retire_valid, 0);
        chk("init_squash", bus.squash, 0);
        chk("init_query_ready", bus.query_ready, 0);
        chk("init_dispatch_ready", bus.dispatch_ready, 1);
        @(negedge clock);
        reset = 1'b1;

        // In-order retire behind out-of-order completion.
        disp(2'b11, 32'd1, 5'd1, 32'd2, 5'd2); step();
        disp(2'b11, 32'd3, 5'd3, 32'd4, 5'd4); step();
        cmpl(0, 5'd2, 32'h22, 1'b0, '0); step();
        cmpl(0, 5'd0, 32'h11, 1'b0, '0); step();
        cmpl(0, 5'd1, 32'h21, 1'b0, '0);
        settle();
        chk("lit_retire_one", bus.retire_valid, 2'b01);
        chk("lit_retire_dest1", bus.retire_dest_reg[4:0], 5'd1);
        chk("lit_retire_val1", bus.retire_value[31:0], 32'h11);
        advance();
        settle();
        chk("lit_retire_two", bus.retire_valid, 2'b11);
        chk("lit_retire_dest23", bus.retire_dest_reg, {5'd3, 5'd2});
        advance();
        drain();

        // Asynchronous reset with five entries in flight.
        disp(2'b11, $urandom, 5'd5, $urandom, 5'd6); step();
        disp(2'b11, $urandom, 5'd7, $urandom, 5'd8); step();
        disp(2'b01, $urandom, 5'd9, $urandom, 5'd0); step();
        settle();
        chk("lit_count5", bus.rob_count, 5);
        advance();
        do_reset();
        settle();
        chk("lit_idx_after_reset", bus.dispatch_idx, {5'd1, 5'd0});
        advance();

        // Fill, hold off, retire two, wrap.
        for (int i = 0; i < ROB_SIZE / DISP_W; i++) begin
            disp(2'b11, $urandom, 5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)));
            step();
        end
        disp(2'b11, $urandom, 5'd1, $urandom, 5'd2);
        settle();
        chk("lit_full_ready", bus.dispatch_ready, 0);
        chk("lit_full_count", bus.rob_count, 32);
        advance();
        cmpl(0, 5'd0, 32'hA0, 1'b0, '0);
        cmpl(1, 5'd1, 32'hA1, 1'b0, '0);
        settle();
        chk("lit_full_hold", bus.rob_count, 32);
        chk("lit_full_tail", bus.dispatch_idx, {5'd1, 5'd0});
        advance();
        settle();
        chk("lit_full_retire", bus.retire_valid, 2'b11);
        chk("lit_full_ready_lag", bus.dispatch_ready, 0);
        advance();
        disp(2'b11, $urandom, 5'd3, $urandom, 5'd4);
        settle();
        chk("lit_ready_again", bus.dispatch_ready, 1);
        chk("lit_wrap_idx", bus.dispatch_idx, {5'd1, 5'd0});
        advance();
        settle();
        chk("lit_refill_count", bus.rob_count, 32);
        advance();
        drain();

        // Mispredicted branch retires in slot 1.
        do_reset();
        disp(2'b11, 32'h10, 5'd1, 32'h14, 5'd2); step();
        disp(2'b11, 32'h18, 5'd3, 32'h1C, 5'd4); step();
        cmpl(0, 5'd2, 32'h33, 1'b0, '0); step();
        cmpl(0, 5'd1, 32'h44, 1'b1, 32'h40);
        cmpl(1, 5'd0, 32'h55, 1'b0, '0);
        step();
        disp(2'b11, 32'h80, 5'd7, 32'h84, 5'd8);
        settle();
        chk("lit_sq_retire", bus.retire_valid, 2'b11);
        chk("lit_sq", bus.squash, 1);
        chk("lit_sq_target", bus.squash_target, 32'h40);
        advance();
        settle();
        chk("lit_sq_count", bus.rob_count, 0);
        chk("lit_sq_idx", bus.dispatch_idx, {5'd1, 5'd0});
        advance();

        // Query bypass, duplicate completion, completion to a free entry.
        for (int i = 0; i < 3; i++) begin
            disp(2'b11, $urandom, 5'd10, $urandom, 5'd11);
            step();
        end
        cmpl(1, 5'd5, 32'd156, 1'b0, '0);
        bus.query_idx[4:0] = 5'd5;
        settle();
        chk("lit_bypass_rdy", bus.query_ready[0], 1);
        chk("lit_bypass_val", bus.query_value[31:0], 32'd156);
        advance();
        bus.query_idx[4:0] = 5'd5;
        settle();
        chk("lit_stored_val", bus.query_value[31:0], 32'd156);
        advance();
        cmpl(0, 5'd3, 32'd7, 1'b0, '0);
        cmpl(1, 5'd3, 32'd9, 1'b0, '0);
        step();
        cmpl(0, 5'd10, 32'd99, 1'b0, '0);
        bus.query_idx[4:0] = 5'd3;
        settle();
        chk("lit_port0_wins", bus.query_value[31:0], 32'd7);
        advance();
        bus.query_idx[9:5] = 5'd10;
        settle();
        chk("lit_invalid_ign", bus.query_ready[1], 0);
        chk("lit_invalid_cnt", bus.rob_count, 6);
        advance();
        drain();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rob_ss.md
Name: rob_ss

Overview:
Parametrised multi-way reorder buffer for the 2-way superscalar P6 core. It replaces the single-issue ROB. Per cycle it accepts up to DISP_W in-order dispatches, up to CMPL_W out-of-order completions from the CDB, and up to RET_W in-order retirements. It flushes on a retiring mispredicted branch and answers operand-tag queries from the reservation stations.

Parameters:
XLEN, 32, data/PC width
ROB_SIZE, 32, entry count; power of 2, >= 2*max(DISP_W,RET_W)
DISP_W, 2, dispatch slots per cycle
CMPL_W, 2, CDB complete ports
RET_W, 2, retire slots per cycle
QRY_W, 4, operand query ports
IDX_W, $clog2(ROB_SIZE), entry index width (derived)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
dispatch_valid  in  DISP_W  per-slot dispatch request; contiguous from slot 0
dispatch_pc  in  DISP_W*XLEN  instruction PC per slot
dispatch_dest_reg  in  DISP_W*5  architectural destination; 0 = none
dispatch_ready  out  1  free entries >= DISP_W
dispatch_idx  out  DISP_W*IDX_W  entry allocated to slot k = (tail+k) mod ROB_SIZE
complete_valid  in  CMPL_W  completion strobe per CDB port
complete_idx  in  CMPL_W*IDX_W  completing entry
complete_value  in  CMPL_W*XLEN  result value
complete_mispred  in  CMPL_W  branch resolved mispredicted
complete_target  in  CMPL_W*XLEN  correct next PC for mispredict
query_idx  in  QRY_W*IDX_W  entry queried by RS
query_ready  out  QRY_W  value available
query_value  out  QRY_W*XLEN  value of queried entry
retire_valid  out  RET_W  slot retires this cycle; contiguous from slot 0
retire_dest_reg  out  RET_W*5  regfile write index; 0 = no write
retire_value  out  RET_W*XLEN  regfile write data
squash  out  1  flush pipeline this cycle
squash_target  out  XLEN  redirect PC
rob_count  out  IDX_W+1  occupied entries
rob_empty  out  1  rob_count == 0

Behaviour:
- Per-entry state: valid, completed, mispred, pc, dest_reg, value, target. Pointers head and tail are IDX_W bits and wrap modulo ROB_SIZE. count is IDX_W+1 bits.
- reset low (async): head=tail=count=0 and all entries invalid. Outputs: dispatch_ready=1, rob_empty=1, retire_valid=0, squash=0, query_ready=0, all data outputs 0.
- Dispatch: a slot is accepted only when dispatch_valid[k] && dispatch_ready. The entry is written at the clock edge and marked valid, not completed. tail advances by the number of accepted slots. Non-contiguous valid (slot1 without slot0) is illegal; the ROB drops slot1. If dispatch_ready=0, dispatch is dropped with no partial accept.
- Complete: at the clock edge, entry[idx] becomes completed and captures value, mispred and target. A completion to an invalid entry is ignored. If two ports name the same entry, the lower port number wins.
- Retire (combinational from registered state): slot j retires if entry (head+j) is valid and completed, and every earlier slot retires. Retirement stops after the first entry with mispred=1. head advances by the retire count at the edge.
- A completion and a retirement of the same entry in the same cycle do not interact: completion is visible for retirement from the next cycle, so completion-to-retire latency is 1 cycle.
- Mispredict: when a retiring slot has mispred=1, squash=1 and squash_target=that entry's target in the same cycle. That slot's regfile write still happens (retire_valid set). At the edge all entries are invalidated, head=tail=count=0, and that cycle's dispatches and completions are discarded.
- count(next) = count + accepted dispatches - retirements. dispatch_ready uses the registered count, so free slots from this cycle's retirements are not visible until the next cycle.
- Query: query_ready=1 if the entry is valid and completed, returning the stored value. It is also 1 on a same-cycle bypass: any complete port with complete_valid and a matching idx, lowest port first, returning complete_value. Otherwise query_ready=0 and query_value=0.
- Full: count==ROB_SIZE gives dispatch_ready=0. Wrap-around: tail or head crossing ROB_SIZE-1→0 is seamless.

Test Plan:
- Reset mid-run with 5 entries occupied, reset low → rob_count=0, rob_empty=1, retire_valid=0 immediately (async); dispatch_idx={1,0} after release.
- Dispatch PCs 1..4 in two cycles (dest 1..4), complete idx 2 then idx 0 → cycle after idx0 completes retire_valid=2'b01 with dest1; after idx1 completes, idx1 and idx2 retire together (retire_valid=2'b11).
- Fill to 32 entries → dispatch_ready=0 and a further dispatch is ignored (tail unchanged). Retire 2 → dispatch_ready=1 one cycle later. Continue dispatching → dispatch_idx wraps {1,0}.
- Entries 0..3 with entry1 complete mispred target=0x40 and entries 0,2 complete → cycle N: retire slots 0,1, squash=1, squash_target=0x40, entry2 not retired. Next cycle: rob_count=0, and the dispatch held during cycle N did not allocate.
- complete_valid on port1 for idx 5, value 156, while query_idx=5 → query_ready=1 and query_value=156 in the same cycle. The next cycle still reads 156 from storage.
- Both CDB ports complete idx 3 with values 7 and 9 → stored value 7. Completion to an invalid idx 10 → no state change.
